rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// ---------------------------------------------------------------------------
// PURPOSE
//   Round-robin arbiter that shares one resource between N requesters.
//   It is the sequential counterpart of our combinational fixed-priority
//   arbiter. The grant is registered and held until the owner releases it.
//   The search pointer rotates after each grant, so no requester starves.
//   Sits between requesting masters and a shared bus, memory port or engine.
// ---------------------------------------------------------------------------
// PARAMETERS
//   N         4   number of requesters, N >= 2
//   MAX_HOLD  8   max consecutive grant cycles; used only with
//                 RR_ARB_HOLD_LIMIT_EN, MAX_HOLD >= 1
//   IDW       $clog2(N)  width of gnt_id (localparam)
// ---------------------------------------------------------------------------
// PORTS
//   clk     in   1    clock, rising edge
//   rst_n   in   1    asynchronous active-low reset
//   req     in   N    request vector, level; bit i = requester i
//   gnt     out  N    registered one-hot grant, all-zero when idle
//   gnt_id  out  IDW  binary index of granted requester, 0 when idle
//   busy    out  1    1 while any grant is held
//   expire  out  1    1-cycle pulse when a hold-limit revoke occurs
//                     (tied 0 when the macro is absent)
// ---------------------------------------------------------------------------
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - gnt=0, gnt_id=0, busy=0, expire=0; state=IDLE; ptr=0; hold_cnt=0.
//     - Takes effect immediately, also mid-grant.
//     - Leaves reset at the first rising clk edge with rst_n=1.
//   State IDLE (gnt=0):
//     - On the edge where req!=0: select the first set bit searching
//       circularly ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//     - Load gnt/gnt_id with it; busy<=1; go to BUSY.
//     - Latency: req sampled at edge k -> gnt visible after edge k.
//     - req==0: stay in IDLE.
//   State BUSY:
//     - gnt held while req[gnt_id]=1. Other req bits are ignored.
//     - req[gnt_id]=0 sampled: gnt<=0, busy<=0, ptr<=(gnt_id+1) mod N,
//       go to IDLE.
//     - One mandatory dead cycle: no direct owner-to-owner handoff.
//   Pointer:
//     - ptr is IDW bits and wraps N-1 -> 0.
//     - For N not a power of 2, ptr never takes a value >= N.
//   Sampling:
//     - Only values sampled at the clock edge matter; glitches between
//       edges are ignored.
//     - A req that rises and falls within one IDLE cycle before an edge
//       is never granted.
//   Invariants:
//     - gnt is always one-hot or zero.
//     - busy == |gnt.
//     - gnt_id matches gnt.
// ---------------------------------------------------------------------------
// CONFIGURATION
//   RR_ARB_HOLD_LIMIT_EN defined:
//     - hold_cnt counts BUSY cycles; it is 1 on the first grant cycle.
//     - If hold_cnt==MAX_HOLD and req[gnt_id] is still 1: revoke.
//       gnt<=0, busy<=0, expire<=1 for one cycle,
//       ptr<=(gnt_id+1) mod N, go to IDLE.
//     - The revoked requester re-arbitrates normally. It is searched
//       last, so others are served first.
//     - A normal release on the same edge as the limit counts as a
//       release: expire=0.
//   RR_ARB_HOLD_LIMIT_EN undefined:
//     - No counter is built. Grants are held indefinitely.
//     - expire is constant 0.
// ---------------------------------------------------------------------------
// TESTING (N=4, MAX_HOLD=4 unless noted)
//   1. Reset: rst_n=0 asynchronously, req=1111
//      -> gnt=0000, gnt_id=0, busy=0, expire=0 with no clock edge.
//   2. ptr=0, req=1010
//      -> gnt=0010 and gnt_id=1 after the next edge.
//      Drop req[1]: gnt=0000 for one cycle, then gnt=1000 (gnt_id=3).
//   3. Fairness, req=1111, each owner releases after 2 cycles:
//      -> grant order 0,1,2,3,0, with one idle cycle between grants.
//   4. Wrap, after a grant to 3 (ptr=0) with req=1001:
//      -> grant goes to 0; after its release, grant goes to 3.
//   5. Macro on: req[0] held high, req[2]=1
//      -> gnt=0001 for exactly 4 cycles, then expire=1 and gnt=0000
//      for one cycle, then gnt=0100.
//      Macro off: gnt=0001 persists for more than 20 cycles.
//   6. Mid-grant reset: gnt=0100, assert rst_n=0 between edges
//      -> gnt=0000 at once. After release of reset with req=1111,
//      gnt=0001 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- registered round-robin arbiter for N requesters.
//
// A requester that wins keeps the grant for as long as it holds its request
// line; every other request is ignored meanwhile. When the owner lets go, the
// grant drops for one dead cycle and the search pointer moves to the slot just
// after the old owner. That slot is searched first next time, so every active
// requester is eventually served.
//
// Optional feature (compile-time macro RR_ARB_HOLD_LIMIT_EN):
//   A grant is revoked after MAX_HOLD consecutive cycles, even if the owner
//   still requests. `expire` pulses for one cycle when that happens. Without
//   the macro no hold counter is built and `expire` is tied to 0.
//
// Parameters
//   N         number of requesters (>= 2)
//   MAX_HOLD  maximum consecutive grant cycles (used only with the macro)
//
// Ports
//   clk     in   1    clock, rising edge
//   rst_n   in   1    asynchronous active-low reset
//   req     in   N    level request vector, bit i = requester i
//   gnt     out  N    registered one-hot grant, zero when idle
//   gnt_id  out  IDW  binary index of the owner, 0 when idle
//   busy    out  1    high while a grant is held
//   expire  out  1    one-cycle pulse on a hold-limit revoke
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           expire
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic [IDW-1:0] id_q,    id_d;
  logic [IDW-1:0] ptr_q,   ptr_d;

  // Circular search result, starting at ptr_q.
  logic           found;
  logic [IDW-1:0] sel_id;

  // Slot after the current owner, wrapping N-1 -> 0 so the pointer never
  // reaches an unused encoding when N is not a power of two.
  logic [IDW-1:0] ptr_after;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          expire_q, expire_d;
`endif

  // -------------------------------------------------------------------------
  // Round-robin search: first set request at ptr, ptr+1, ..., wrapping.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    found  = 1'b0;
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N]) begin
        found  = 1'b1;
        sel_id = IDW'((int'(ptr_q) + i) % N);
      end
    end
  end

  assign ptr_after = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q   <= '0;
      expire_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q   <= hold_d;
      expire_q <= expire_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_d   = hold_q;
    expire_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = N'(1) << sel_id;
          id_d    = sel_id;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d  = HW'(1);  // the first grant cycle counts as one
`endif
        end
      end
      BUSY: begin
        if (!req[id_q]) begin
          // Normal release; wins over a limit reached on the same edge.
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          ptr_d   = ptr_after;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d  = '0;
        end else if (hold_q == HW'(MAX_HOLD)) begin
          // Owner overstayed: revoke and search it last next time.
          state_d  = IDLE;
          gnt_d    = '0;
          id_d     = '0;
          ptr_d    = ptr_after;
          hold_d   = '0;
          expire_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: all come straight from registers.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt    = gnt_q;
    gnt_id = id_q;
    busy   = (state_q == BUSY);
`ifdef RR_ARB_HOLD_LIMIT_EN
    expire = expire_q;
`else
    expire = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter -- self-checking bench for rr_arbiter (N=4, MAX_HOLD=4).
// Each scenario task drives req a cycle at a time, pushes the outputs it
// expects after the next rising edge into a scoreboard queue, and pops and
// compares them 1 ns after that edge. Reset behaviour is checked between
// edges. Honours RR_ARB_HOLD_LIMIT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
    logic           expire;
  } obs_t;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           expire;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .expire (expire)
  );

  always #5 clk = ~clk;

  // Expected output bundle from an expected grant vector.
  function automatic obs_t mk(input logic [N-1:0] g, input logic e);
    obs_t o;
    o.gnt    = g;
    o.id     = '0;
    for (int i = 0; i < N; i++)
      if (g[i]) o.id = IDW'(i);
    o.busy   = |g;
    o.expire = e;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.gnt    = gnt;
    o.id     = gnt_id;
    o.busy   = busy;
    o.expire = expire;
    return o;
  endfunction

  // Stimulus only: reset, then leave at posedge+1 with ptr=0 and IDLE.
  task automatic do_reset();
    req = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    obs_t e, o;
    #1 rst_n = 1'b0;
    req = 4'b1111;
    #1;  // still before the first clock edge
    e = mk(4'b0000, 1'b0); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_async: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      o = cur(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_held[%0d]: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
                 c, o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(mk(4'b0001, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_first_grant: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
  endtask

  // -------------------------------------------------------------------------
  // Grant, hold with other requests ignored, dead cycle, handoff, and wrap.
  task automatic test_basic();
    logic [N-1:0] rq [9] = '{4'b1010, 4'b1011, 4'b1000, 4'b1000, 4'b0001,
                             4'b1001, 4'b1000, 4'b1000, 4'b0000};
    logic [N-1:0] eg [9] = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000,
                             4'b0001, 4'b0000, 4'b1000, 4'b0000};
    obs_t e, o;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req = rq[c];
      exp_q.push_back(mk(eg[c], 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic[%0d] req=%b: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
                 c, rq[c], o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // All four requesting, each owner releasing after two grant cycles.
  task automatic test_fairness();
    int           order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] g;
    obs_t         e, o;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      g = N'(1) << order[k];
      for (int c = 0; c < 3; c++) begin
        req = (c < 2) ? 4'b1111 : (4'b1111 & ~g);
        exp_q.push_back(mk((c < 2) ? g : 4'b0000, 1'b0));
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = cur(); n_cmp++;
        if (o !== e) begin
          n_err++;
          $display("FAIL fairness[%0d.%0d]: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
                   k, c, o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
        end
      end
    end
    req = '0;
  endtask

  // -------------------------------------------------------------------------
  // A request pulse that starts and ends between two edges is never seen.
  task automatic test_glitch();
    obs_t e, o;
    do_reset();
    exp_q.push_back(mk(4'b0000, 1'b0));
    #3 req = 4'b0010;
    #3 req = 4'b0000;
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL glitch: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold_limit();
`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int L = 12;
    // Revoke after 4 cycles, hand to 2; then 2 releases exactly at the limit.
    logic [N-1:0] rq [L] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                             4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    logic [N-1:0] eg [L] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100,
                             4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    logic         ee [L] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    localparam int L = 23;
    logic [N-1:0] rq [L];
    logic [N-1:0] eg [L];
    logic         ee [L];
`endif
    obs_t e, o;
`ifndef RR_ARB_HOLD_LIMIT_EN
    // Without the limit the grant to 0 must persist well past 20 cycles.
    for (int c = 0; c < L; c++) begin
      rq[c] = (c < L - 1) ? 4'b0101 : 4'b0000;
      eg[c] = (c < L - 1) ? 4'b0001 : 4'b0000;
      ee[c] = 1'b0;
    end
`endif
    do_reset();
    for (int c = 0; c < L; c++) begin
      req = rq[c];
      exp_q.push_back(mk(eg[c], ee[c]));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL hold[%0d] req=%b: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
                 c, rq[c], o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_midgrant_reset();
    obs_t e, o;
    do_reset();
    req = 4'b0100;
    exp_q.push_back(mk(4'b0100, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL midreset_grant: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
    #1 rst_n = 1'b0;
    #1;
    e = mk(4'b0000, 1'b0); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL midreset_async: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
    req = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(4'b0001, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL midreset_after: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
    req = '0;
    exp_q.push_back(mk(4'b0000, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL midreset_release: got gnt=%b id=%0d busy=%b expire=%b, want gnt=%b id=%0d busy=%b expire=%b",
               o.gnt, o.id, o.busy, o.expire, e.gnt, e.id, e.busy, e.expire);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_glitch();
    test_hold_limit();
    test_midgrant_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
